// File: rtl/aes_seq_pkg.sv
// Shared definitions for the AES vector sequencer: FSM state codes, default
// bus widths and the idle-scrambler LFSR constants and step function.
package aes_seq_pkg;

    localparam int DATA_W_DEF = 128;
    localparam int KEY_W_DEF  = 128;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_ISSUE = 3'd1;
    localparam state_t ST_WAIT  = 3'd2;
    localparam state_t ST_CHECK = 3'd3;
    localparam state_t ST_GAP   = 3'd4;
    localparam state_t ST_DONE  = 3'd5;

    // Fibonacci LFSR, taps 32,22,2,1 -> bit positions 31,21,1,0
    localparam logic [31:0] LFSR_SEED = 32'hACE1_2024;
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
        return {cur[30:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/aes_seq_vec_mem.sv
// Vector slot storage: NUM_VEC entries of {plaintext, key, expected}.
// One synchronous write port, one asynchronous read port. Not reset, so
// programmed vectors survive a sequencer reset.
module aes_seq_vec_mem
    import aes_seq_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int KEY_W   = KEY_W_DEF,
    parameter int NUM_VEC = 4,
    parameter int IDX_W   = $clog2(NUM_VEC)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_pt,
    input  logic [KEY_W-1:0]  wr_key,
    input  logic [DATA_W-1:0] wr_exp,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_pt,
    output logic [KEY_W-1:0]  rd_key,
    output logic [DATA_W-1:0] rd_exp
);

    localparam int ENT_W = 2 * DATA_W + KEY_W;

    logic [ENT_W-1:0] mem_r [NUM_VEC];

    // Write one slot; gating against a running sequence is done by the caller
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_idx] <= {wr_pt, wr_key, wr_exp};
        end
    end

    assign {rd_pt, rd_key, rd_exp} = mem_r[rd_idx];

endmodule

// File: rtl/aes_vector_sequencer.sv
// Programmable stimulus/checker in front of AES_top. Steps through the vector
// slots, holds AES_en for EN_HOLD cycles, captures the first result per vector,
// compares it and keeps saturating pass/fail/timeout counts.
// Optional build macro AES_SEQ_IDLE_SCRAMBLE_EN: drive an LFSR pattern onto
// AES_data_in during GAP instead of zero.
module aes_vector_sequencer
    import aes_seq_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int KEY_W   = KEY_W_DEF,
    parameter int NUM_VEC = 4,
    parameter int IDX_W   = $clog2(NUM_VEC),
    parameter int EN_HOLD = 51,
    parameter int GAP     = 15,
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 16
) (
    input  logic              AES_clk,
    input  logic              AES_rst,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_mode,
    input  logic              vec_wr_en,
    input  logic [IDX_W-1:0]  vec_wr_idx,
    input  logic [DATA_W-1:0] vec_wr_pt,
    input  logic [KEY_W-1:0]  vec_wr_key,
    input  logic [DATA_W-1:0] vec_wr_exp,
    output logic              AES_en,
    output logic [DATA_W-1:0] AES_data_in,
    output logic [KEY_W-1:0]  AES_key_in,
    input  logic [DATA_W-1:0] AES_data_out,
    input  logic              AES_data_out_valid,
    output logic              busy,
    output logic              done,
    output logic [IDX_W-1:0]  cur_idx,
    output logic [DATA_W-1:0] last_result,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic [CNT_W-1:0]  tmo_cnt
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam int GAP_W = $clog2(GAP + 2);

    state_t            state_r, state_nxt_s, exit_state_s, leave_state_s;
    logic [IDX_W-1:0]  idx_r, idx_nxt_s, idx_inc_s, exit_idx_s, leave_idx_s;
    logic [TMR_W-1:0]  tmr_r;
    logic [GAP_W-1:0]  gap_cnt_r;
    logic              captured_r, loop_r, stop_pend_r;
    logic              last_s, stop_any_s, capture_s, enter_issue_s, busy_st_s;
    logic              pass_inc_s, fail_inc_s, tmo_inc_s;
    logic [DATA_W-1:0] exp_r, last_result_r, data_in_r, gap_data_s;
    logic [KEY_W-1:0]  key_in_r;
    logic              aes_en_r, busy_r, done_r;
    logic [CNT_W-1:0]  pass_cnt_r, fail_cnt_r, tmo_cnt_r;
    logic [DATA_W-1:0] rd_pt_s, rd_exp_s;
    logic [KEY_W-1:0]  rd_key_s;

    // Memory is read at the slot about to be issued, so the bus registers can
    // be loaded on the same edge that enters ISSUE.
    aes_seq_vec_mem #(
        .DATA_W (DATA_W),
        .KEY_W  (KEY_W),
        .NUM_VEC(NUM_VEC),
        .IDX_W  (IDX_W)
    ) u_mem (
        .clk   (AES_clk),
        .wr_en (vec_wr_en & ~busy_st_s),
        .wr_idx(vec_wr_idx),
        .wr_pt (vec_wr_pt),
        .wr_key(vec_wr_key),
        .wr_exp(vec_wr_exp),
        .rd_idx(idx_nxt_s),
        .rd_pt (rd_pt_s),
        .rd_key(rd_key_s),
        .rd_exp(rd_exp_s)
    );

    assign busy_st_s     = (state_r == ST_ISSUE) || (state_r == ST_WAIT) ||
                           (state_r == ST_CHECK) || (state_r == ST_GAP);
    assign enter_issue_s = (state_nxt_s == ST_ISSUE) && (state_r != ST_ISSUE);

    // End-of-vector routing: where to go after GAP, and where to go after
    // CHECK/timeout (straight to the GAP exit target when GAP is zero)
    always_comb begin
        last_s     = (idx_r == IDX_W'(NUM_VEC - 1));
        stop_any_s = stop_pend_r | stop;
        if (last_s) begin
            idx_inc_s = {IDX_W{1'b0}};
        end else begin
            idx_inc_s = idx_r + IDX_W'(1);
        end
        if (stop_any_s || (last_s && !loop_r)) begin
            exit_state_s = ST_DONE;
            exit_idx_s   = idx_r;
        end else begin
            exit_state_s = ST_ISSUE;
            exit_idx_s   = idx_inc_s;
        end
        if (GAP != 0) begin
            leave_state_s = ST_GAP;
            leave_idx_s   = idx_r;
        end else begin
            leave_state_s = exit_state_s;
            leave_idx_s   = exit_idx_s;
        end
    end

    // Main sequencing FSM: next state, slot index, capture and count strobes
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        capture_s   = 1'b0;
        pass_inc_s  = 1'b0;
        fail_inc_s  = 1'b0;
        tmo_inc_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_ISSUE;
                    idx_nxt_s   = {IDX_W{1'b0}};
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                capture_s = AES_data_out_valid & ~captured_r;
                if (tmr_r == TMR_W'(EN_HOLD - 1)) begin
                    if (captured_r || AES_data_out_valid) begin
                        state_nxt_s = ST_CHECK;
                    end else begin
                        state_nxt_s = ST_WAIT;
                    end
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                capture_s = AES_data_out_valid;
                if (AES_data_out_valid) begin
                    state_nxt_s = ST_CHECK;
                end else if (tmr_r == TMR_W'(TIMEOUT - 1)) begin
                    tmo_inc_s   = 1'b1;
                    state_nxt_s = leave_state_s;
                    idx_nxt_s   = leave_idx_s;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_CHECK: begin
                if (last_result_r == exp_r) begin
                    pass_inc_s = 1'b1;
                end else begin
                    fail_inc_s = 1'b1;
                end
                state_nxt_s = leave_state_s;
                idx_nxt_s   = leave_idx_s;
            end
            ST_GAP: begin
                if (gap_cnt_r == GAP_W'(GAP - 1)) begin
                    state_nxt_s = exit_state_s;
                    idx_nxt_s   = exit_idx_s;
                end else begin
                    state_nxt_s = ST_GAP;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

`ifdef AES_SEQ_IDLE_SCRAMBLE_EN
    logic [31:0] lfsr_r;

    // Idle scrambler: advances once per GAP cycle, otherwise holds
    always_ff @(posedge AES_clk) begin
        if (AES_rst) begin
            lfsr_r <= LFSR_SEED;
        end else if (state_nxt_s == ST_GAP) begin
            lfsr_r <= lfsr_next(lfsr_r);
        end
    end

    // Replicate the 32-bit LFSR word across the whole data bus
    always_comb begin
        gap_data_s = {DATA_W{1'b0}};
        for (int i = 0; i < DATA_W; i++) begin
            gap_data_s[i] = lfsr_r[i % 32];
        end
    end
`else
    assign gap_data_s = {DATA_W{1'b0}};
`endif

    // FSM state, slot index, cycle timers and per-run control flags
    always_ff @(posedge AES_clk) begin
        if (AES_rst) begin
            state_r     <= ST_IDLE;
            idx_r       <= {IDX_W{1'b0}};
            tmr_r       <= {TMR_W{1'b0}};
            gap_cnt_r   <= {GAP_W{1'b0}};
            captured_r  <= 1'b0;
            loop_r      <= 1'b0;
            stop_pend_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
            if (enter_issue_s) begin
                tmr_r <= {TMR_W{1'b0}};
            end else if ((state_r == ST_ISSUE) || (state_r == ST_WAIT)) begin
                tmr_r <= tmr_r + TMR_W'(1);
            end
            if (state_r == ST_GAP) begin
                gap_cnt_r <= gap_cnt_r + GAP_W'(1);
            end else begin
                gap_cnt_r <= {GAP_W{1'b0}};
            end
            if (enter_issue_s) begin
                captured_r <= 1'b0;
            end else if (capture_s) begin
                captured_r <= 1'b1;
            end
            if ((state_r == ST_IDLE) && start) begin
                loop_r      <= loop_mode;
                stop_pend_r <= 1'b0;
            end else if (busy_st_s && stop) begin
                stop_pend_r <= 1'b1;
            end
        end
    end

    // Result capture and saturating pass/fail/timeout counters
    always_ff @(posedge AES_clk) begin
        if (AES_rst) begin
            last_result_r <= {DATA_W{1'b0}};
            pass_cnt_r    <= {CNT_W{1'b0}};
            fail_cnt_r    <= {CNT_W{1'b0}};
            tmo_cnt_r     <= {CNT_W{1'b0}};
        end else begin
            if (capture_s) begin
                last_result_r <= AES_data_out;
            end
            if ((state_r == ST_IDLE) && start) begin
                pass_cnt_r <= {CNT_W{1'b0}};
                fail_cnt_r <= {CNT_W{1'b0}};
                tmo_cnt_r  <= {CNT_W{1'b0}};
            end else begin
                if (pass_inc_s && (pass_cnt_r != {CNT_W{1'b1}})) begin
                    pass_cnt_r <= pass_cnt_r + CNT_W'(1);
                end
                if (fail_inc_s && (fail_cnt_r != {CNT_W{1'b1}})) begin
                    fail_cnt_r <= fail_cnt_r + CNT_W'(1);
                end
                if (tmo_inc_s && (tmo_cnt_r != {CNT_W{1'b1}})) begin
                    tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
                end
            end
        end
    end

    // Registered AES bus and status outputs, decoded from the next state
    always_ff @(posedge AES_clk) begin
        if (AES_rst) begin
            aes_en_r  <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            data_in_r <= {DATA_W{1'b0}};
            key_in_r  <= {KEY_W{1'b0}};
            exp_r     <= {DATA_W{1'b0}};
        end else begin
            aes_en_r <= (state_nxt_s == ST_ISSUE);
            busy_r   <= (state_nxt_s == ST_ISSUE) || (state_nxt_s == ST_WAIT) ||
                        (state_nxt_s == ST_CHECK) || (state_nxt_s == ST_GAP);
            done_r   <= (state_nxt_s == ST_DONE);
            if (enter_issue_s) begin
                data_in_r <= rd_pt_s;
                key_in_r  <= rd_key_s;
                exp_r     <= rd_exp_s;
            end else if (state_nxt_s == ST_GAP) begin
                data_in_r <= gap_data_s;
            end else if ((state_nxt_s == ST_IDLE) || (state_nxt_s == ST_DONE)) begin
                data_in_r <= {DATA_W{1'b0}};
            end
        end
    end

    assign AES_en      = aes_en_r;
    assign AES_data_in = data_in_r;
    assign AES_key_in  = key_in_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign cur_idx     = idx_r;
    assign last_result = last_result_r;
    assign pass_cnt    = pass_cnt_r;
    assign fail_cnt    = fail_cnt_r;
    assign tmo_cnt     = tmo_cnt_r;

endmodule

// File: tb/tb_aes_vector_sequencer.sv
// Self-checking bench for aes_vector_sequencer with a behavioural AES stub.
module tb_aes_vector_sequencer;

    localparam int DATA_W  = 128;
    localparam int KEY_W   = 128;
    localparam int NUM_VEC = 4;
    localparam int IDX_W   = 2;
    localparam int EN_HOLD = 51;
    localparam int GAP_C   = 15;
    localparam int TIMEOUT = 256;
    localparam int CNT_W   = 16;

    logic              AES_clk = 1'b0;
    logic              AES_rst = 1'b1;
    logic              start = 1'b0, stop = 1'b0, loop_mode = 1'b0;
    logic              vec_wr_en = 1'b0;
    logic [IDX_W-1:0]  vec_wr_idx = '0;
    logic [DATA_W-1:0] vec_wr_pt = '0, vec_wr_exp = '0;
    logic [KEY_W-1:0]  vec_wr_key = '0;
    logic              AES_en, busy, done;
    logic [DATA_W-1:0] AES_data_in, last_result;
    logic [KEY_W-1:0]  AES_key_in;
    logic [DATA_W-1:0] AES_data_out = '0;
    logic              AES_data_out_valid = 1'b0;
    logic [IDX_W-1:0]  cur_idx;
    logic [CNT_W-1:0]  pass_cnt, fail_cnt, tmo_cnt;

    always #5 AES_clk = ~AES_clk;

    aes_vector_sequencer #(
        .DATA_W(DATA_W), .KEY_W(KEY_W), .NUM_VEC(NUM_VEC), .IDX_W(IDX_W),
        .EN_HOLD(EN_HOLD), .GAP(GAP_C), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .AES_clk(AES_clk), .AES_rst(AES_rst), .start(start), .stop(stop),
        .loop_mode(loop_mode), .vec_wr_en(vec_wr_en), .vec_wr_idx(vec_wr_idx),
        .vec_wr_pt(vec_wr_pt), .vec_wr_key(vec_wr_key), .vec_wr_exp(vec_wr_exp),
        .AES_en(AES_en), .AES_data_in(AES_data_in), .AES_key_in(AES_key_in),
        .AES_data_out(AES_data_out), .AES_data_out_valid(AES_data_out_valid),
        .busy(busy), .done(done), .cur_idx(cur_idx), .last_result(last_result),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .tmo_cnt(tmo_cnt)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: slot contents as the spec says they should be
    logic [DATA_W-1:0] m_pt [NUM_VEC];
    logic [KEY_W-1:0]  m_key[NUM_VEC];
    logic [DATA_W-1:0] m_exp[NUM_VEC];
    logic [DATA_W-1:0] stub_resp[NUM_VEC];
    bit tb_running = 1'b0;

    // Stub behaviour: 0 = never valid, 1 = one valid, 2 = extra valids incl. GAP
    int stub_mode  = 1;
    int stub_delay = 20;

    // Monitor statistics
    int   st_t = 0;
    logic en_q = 1'b0;
    int   en_len = 0, en_total = 0, en_len_bad = 0, bus_err = 0;
    int   done_cnt = 0, tmo_lat_bad = 0;
    logic [CNT_W-1:0] tmo_q = '0;
    int   idx_q[$];
    int   exp_seq[$];

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // AES stub and bus monitor, evaluated mid-cycle
    always @(negedge AES_clk) begin
        if (AES_en && !en_q) begin
            st_t   = 0;
            en_len = 1;
            idx_q.push_back(int'(cur_idx));
            if (AES_data_in !== m_pt[cur_idx] || AES_key_in !== m_key[cur_idx]) bus_err++;
        end else begin
            st_t++;
            if (AES_en) en_len++;
        end
        if (!AES_en && en_q) begin
            en_total += en_len;
            if (en_len != EN_HOLD) en_len_bad++;
        end
        if (tmo_cnt > tmo_q && st_t != TIMEOUT) tmo_lat_bad++;
        tmo_q = tmo_cnt;
        if (done) done_cnt++;
        en_q = AES_en;
        AES_data_out_valid = 1'b0;
        AES_data_out       = rand128();
        if (stub_mode != 0 && st_t == stub_delay) begin
            AES_data_out_valid = 1'b1;
            AES_data_out       = stub_resp[cur_idx];
        end
        if (stub_mode == 2 && (st_t == stub_delay + 5 || st_t == 55)) begin
            AES_data_out_valid = 1'b1;
            AES_data_out       = ~stub_resp[cur_idx];
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr_vec(input int i, input logic [127:0] pt, input logic [127:0] key,
                          input logic [127:0] ex);
        @(negedge AES_clk);
        vec_wr_en  = 1'b1;
        vec_wr_idx = IDX_W'(i);
        vec_wr_pt  = pt;
        vec_wr_key = key;
        vec_wr_exp = ex;
        @(negedge AES_clk);
        vec_wr_en = 1'b0;
        if (!tb_running) begin
            m_pt[i]  = pt;
            m_key[i] = key;
            m_exp[i] = ex;
        end
    endtask

    task automatic do_start(input logic lp);
        en_total = 0; en_len_bad = 0; bus_err = 0; done_cnt = 0; tmo_lat_bad = 0;
        idx_q.delete();
        @(negedge AES_clk);
        loop_mode = lp;
        start     = 1'b1;
        @(negedge AES_clk);
        start      = 1'b0;
        tb_running = 1'b1;
    endtask

    task automatic pulse(input bit is_stop);
        @(negedge AES_clk);
        if (is_stop) stop = 1'b1; else start = 1'b1;
        @(negedge AES_clk);
        stop  = 1'b0;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge AES_clk);
            n++;
        end
        check({tag, "_done_seen"}, done, 1'b1);
        tb_running = 1'b0;
        @(negedge AES_clk);
        check({tag, "_done_pulse"}, done, 1'b0);
        check({tag, "_busy_low"}, busy, 1'b0);
    endtask

    // Compare DUT against the model's view of the processed slot sequence
    task automatic check_run(input string tag);
        int p = 0, f = 0, t = 0, mism = 0;
        foreach (exp_seq[i]) begin
            if (stub_mode == 0) t++;
            else if (stub_resp[exp_seq[i]] === m_exp[exp_seq[i]]) p++;
            else f++;
        end
        for (int i = 0; i < exp_seq.size() && i < idx_q.size(); i++)
            if (idx_q[i] != exp_seq[i]) mism++;
        check({tag, "_pass_cnt"}, pass_cnt, p);
        check({tag, "_fail_cnt"}, fail_cnt, f);
        check({tag, "_tmo_cnt"}, tmo_cnt, t);
        check({tag, "_idx_len"}, idx_q.size(), exp_seq.size());
        check({tag, "_idx_seq"}, mism, 0);
        check({tag, "_en_hold"}, en_len_bad, 0);
        check({tag, "_bus"}, bus_err, 0);
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_tmo_lat"}, tmo_lat_bad, 0);
        if (stub_mode != 0)
            check({tag, "_last_result"}, last_result, stub_resp[exp_seq[exp_seq.size() - 1]]);
    endtask

    initial begin
        logic [127:0] ct;
        // Reset state
        repeat (3) @(negedge AES_clk);
        check("rst_en", AES_en, 1'b0);
        check("rst_data", AES_data_in, 128'h0);
        check("rst_key", AES_key_in, 128'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_cnts", {pass_cnt, fail_cnt, tmo_cnt}, 48'h0);
        check("rst_last", last_result, 128'h0);
        check("rst_idx", cur_idx, 2'd0);
        AES_rst = 1'b0;

        // FIPS-197 single vector: stop early in slot 0
        wr_vec(0, 128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
               128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        stub_resp[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        for (int i = 1; i < NUM_VEC; i++) wr_vec(i, rand128(), rand128(), rand128());
        stub_mode = 1;
        do_start(1'b0);
        repeat (5) @(negedge AES_clk);
        pulse(1'b1);
        wait_done("fips", 2000);
        exp_seq = '{0};
        check_run("fips");
        check("fips_en_total", en_total, EN_HOLD);

        // Four random vectors, slot 2 expected value corrupted; mid-run start ignored
        for (int i = 0; i < NUM_VEC; i++) begin
            ct = rand128();
            stub_resp[i] = ct;
            wr_vec(i, rand128(), rand128(), (i == 2) ? ~ct : ct);
        end
        do_start(1'b0);
        repeat (80) @(negedge AES_clk);
        pulse(1'b0);
        wait_done("four", 2000);
        exp_seq = '{0, 1, 2, 3};
        check_run("four");

        // Stub never answers: one timeout per vector
        stub_mode = 0;
        do_start(1'b0);
        wait_done("tmo", 3000);
        check_run("tmo");

        // Loop mode, stop during slot 1 of the second pass
        wr_vec(2, m_pt[2], m_key[2], stub_resp[2]);
        stub_mode = 1;
        do_start(1'b1);
        for (int n = 0; idx_q.size() < 6 && n < 1000; n++) @(negedge AES_clk);
        check("loop_reach_pass2", idx_q.size(), 6);
        pulse(1'b1);
        wait_done("loop", 2000);
        exp_seq = '{0, 1, 2, 3, 0, 1};
        check_run("loop");

        // Reset during WAIT, then rerun with retained vectors
        stub_mode = 0;
        do_start(1'b0);
        repeat (100) @(negedge AES_clk);
        AES_rst = 1'b1;
        @(negedge AES_clk);
        check("midrst_en", AES_en, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_cnts", {pass_cnt, fail_cnt, tmo_cnt}, 48'h0);
        check("midrst_idx", cur_idx, 2'd0);
        AES_rst    = 1'b0;
        tb_running = 1'b0;
        stub_mode  = 1;
        do_start(1'b0);
        wait_done("rerun", 2000);
        exp_seq = '{0, 1, 2, 3};
        check_run("rerun");

        // Duplicate and GAP valids, plus a write attempt while busy
        stub_mode = 2;
        do_start(1'b0);
        repeat (10) @(negedge AES_clk);
        wr_vec(1, rand128(), rand128(), rand128());
        wait_done("dupv", 2000);
        check_run("dupv");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/aes_vector_sequencer.md
Name: aes_vector_sequencer

Overview:
- Synthesizable on-chip stimulus/checker placed in front of AES_top; replaces the fixed hand-timed stimulus with a programmable sequence.
- Holds NUM_VEC (plaintext, key, expected ciphertext) triples, drives AES_en/AES_data_in/AES_key_in with a programmable enable-hold time, and captures AES_data_out on AES_data_out_valid.
- Compares each result against the expected value and keeps pass/fail/timeout counts.
- Supports single-pass and continuous-loop modes for power/VCD capture runs.

Parameters:
- DATA_W, 128, plaintext/ciphertext width.
- KEY_W, 128, key width.
- NUM_VEC, 4, vector slots (≥2).
- IDX_W, $clog2(NUM_VEC), slot index width.
- EN_HOLD, 51, cycles AES_en is held high per vector (≥1).
- GAP, 15, idle cycles between vectors (≥0).
- TIMEOUT, 256, max cycles to wait for valid after the first ISSUE cycle.
- CNT_W, 16, counter width.

Ports:
- AES_clk  in  1  clock, all logic rising-edge.
- AES_rst  in  1  synchronous active-high reset.
- start  in  1  pulse; begins a run from slot 0.
- stop  in  1  pulse; finish current vector, then DONE.
- loop_mode  in  1  sampled at start; 1 = wrap after last slot.
- vec_wr_en  in  1  write one vector slot.
- vec_wr_idx  in  IDX_W  slot to write.
- vec_wr_pt  in  DATA_W  plaintext.
- vec_wr_key  in  KEY_W  key.
- vec_wr_exp  in  DATA_W  expected ciphertext.
- AES_en  out  1  to AES_top.
- AES_data_in  out  DATA_W  to AES_top.
- AES_key_in  out  KEY_W  to AES_top.
- AES_data_out  in  DATA_W  from AES_top.
- AES_data_out_valid  in  1  from AES_top.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at run end.
- cur_idx  out  IDX_W  slot being processed.
- last_result  out  DATA_W  last captured ciphertext.
- pass_cnt / fail_cnt / tmo_cnt  out  CNT_W each  saturating counters.

Behaviour:
- Reset:
  - FSM to IDLE; all outputs 0 (AES_en=0, AES_data_in=0, AES_key_in=0, busy=0, done=0, counters=0, last_result=0, cur_idx=0).
  - Vector memory is not reset.
- States and transitions:
  - IDLE: on start → ISSUE; counters cleared, cur_idx=0, loop_mode latched.
  - ISSUE: AES_en=1; AES_data_in/AES_key_in = slot[cur_idx]. Lasts exactly EN_HOLD cycles, then → WAIT, or → CHECK if a result was already captured.
  - WAIT: AES_en=0, data/key held. Wait timer starts at the first ISSUE cycle. On valid → CHECK. If the timer reaches TIMEOUT with no valid: tmo_cnt+1, → GAP.
  - CHECK (1 cycle): last_result == slot.exp ? pass_cnt+1 : fail_cnt+1; → GAP.
  - GAP: AES_en=0, AES_data_in=0, key held, for GAP cycles (GAP=0 → 0 cycles). Exit rules:
    - stop_pending → DONE.
    - cur_idx==NUM_VEC-1 and loop off → DONE.
    - Otherwise → ISSUE with cur_idx+1, wrapping to 0 when loop is on.
  - DONE (1 cycle): done=1, busy=0 → IDLE.
- Result capture:
  - Only the first AES_data_out_valid after entering ISSUE is captured; later valids for the same vector are ignored.
  - A valid seen in GAP or IDLE is ignored.
- busy=1 in ISSUE/WAIT/CHECK/GAP.
- start while busy: ignored.
- stop: sets stop_pending while busy; ignored in IDLE.
- vec_wr_en: honoured only when busy=0; ignored while busy.
- Counters saturate at 2^CNT_W-1.
- Same-cycle valid and timeout: valid wins.
- AES_rst mid-run: immediate return to reset state, AES_en dropped the same cycle.

Optional Feature:
- Macro AES_SEQ_IDLE_SCRAMBLE_EN.
- Defined: during GAP, AES_data_in is driven by a 32-bit Fibonacci LFSR (taps 32,22,2,1, seed 32'hACE1_2024, reset to seed) replicated across DATA_W, advancing each GAP cycle. This exercises data-bus toggling while AES_en=0.
- Undefined: AES_data_in=0 in GAP; no LFSR logic present.

Decomposition:
- Package aes_seq_pkg:
  - state enum (IDLE, ISSUE, WAIT, CHECK, GAP, DONE).
  - LFSR seed/tap constants.
  - default DATA_W/KEY_W.
- Sub-module aes_seq_vec_mem: NUM_VEC-deep register file, one write port, one async read port, 2*DATA_W+KEY_W wide.

Test Plan:
- Single FIPS-197 vector (pt 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f), stub returns 69c4e0d86a7b0430d8cdb78070b4c55a 20 cycles after first ISSUE → AES_en high exactly 51 cycles, pass_cnt=1, done pulse, busy low.
- 4 vectors, slot 2 expected value corrupted → pass_cnt=3, fail_cnt=1, cur_idx sequence 0,1,2,3.
- Stub never asserts valid, TIMEOUT=256 → tmo_cnt=1 per vector, 256 cycles from first ISSUE to GAP.
- loop_mode=1, stop asserted during slot 1 of the 2nd pass → run ends after slot 1 completes; pass_cnt=6.
- AES_rst during WAIT, then start again → all counters 0, AES_en=0 the cycle after reset; vectors retained, second run passes.
- Stub asserts valid twice and again in GAP, with a vec_wr attempt while busy → only one count per vector; memory unchanged.
